// File: rtl/lock_ctrl.sv
// lock_ctrl: 4-digit keypad password lock with entry timeout and failure lockout.
// Define LOCK_CODE_CHANGE_EN to allow rewriting the code from OPEN via '#'.
module lock_ctrl #(
   parameter logic [15:0] DEFAULT_CODE = 16'h1234,
   parameter int          OPEN_CYCLES  = 250_000_000,
   parameter int          FAIL_CYCLES  = 50_000_000,
   parameter int          LOCK_CYCLES  = 500_000_000,
   parameter int          IDLE_CYCLES  = 500_000_000,
   parameter int          MAX_FAIL     = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_flag,
   input  logic [3:0] key_value,
   output logic       unlock,
   output logic       fail,
   output logic       alarm,
   output logic [2:0] digit_cnt,
   output logic [1:0] err_cnt,
   output logic       code_upd
);
   localparam logic [28:0] OPEN_LAST = 29'(OPEN_CYCLES - 1);
   localparam logic [28:0] FAIL_LAST = 29'(FAIL_CYCLES - 1);
   localparam logic [28:0] LOCK_LAST = 29'(LOCK_CYCLES - 1);
   localparam logic [28:0] IDLE_LAST = 29'(IDLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_FAIL, S_LOCKOUT, S_NEWCODE
   } state_t;

   state_t      state, next_state;
   logic        flag_d;
   logic        is_digit, is_clear, is_enter;
   logic        key_ok, expired;
   logic [28:0] timer;
   logic [15:0] buffer, buffer_next, code;
   logic [2:0]  cnt_next;
   logic [1:0]  err_next, err_inc;
`ifdef LOCK_CODE_CHANGE_EN
   logic        code_wr;
`endif

   // key_value is only meaningful on the cycle after the scanner strobe
   assign is_digit = flag_d && (key_value < 4'd10);
   assign is_clear = flag_d && (key_value == 4'd10);
   assign is_enter = flag_d && (key_value == 4'd11);
   assign err_inc  = err_cnt + 2'd1;

   always_comb begin
      case (state)
         S_ENTRY, S_NEWCODE: expired = (timer == IDLE_LAST);
         S_OPEN:             expired = (timer == OPEN_LAST);
         S_FAIL:             expired = (timer == FAIL_LAST);
         S_LOCKOUT:          expired = (timer == LOCK_LAST);
         default:            expired = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state  = state;
      buffer_next = buffer;
      cnt_next    = digit_cnt;
      err_next    = err_cnt;
      key_ok      = 1'b0;
`ifdef LOCK_CODE_CHANGE_EN
      code_wr     = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (is_digit) begin
               buffer_next = {12'h000, key_value};
               cnt_next    = 3'd1;
               key_ok      = 1'b1;
               next_state  = S_ENTRY;
            end
         end
         S_ENTRY, S_NEWCODE: begin
            // timeout takes priority over a key arriving in the same cycle
            if (expired) begin
               buffer_next = '0;
               cnt_next    = '0;
               next_state  = S_IDLE;
            end else if (is_digit) begin
               key_ok = 1'b1;
               if (digit_cnt < 3'd4) begin
                  buffer_next = {buffer[11:0], key_value};
                  cnt_next    = digit_cnt + 3'd1;
               end
            end else if (is_clear) begin
               buffer_next = '0;
               cnt_next    = '0;
               next_state  = S_IDLE;
            end else if (is_enter) begin
               if (state == S_ENTRY) begin
                  next_state = S_CHECK;
               end else begin
`ifdef LOCK_CODE_CHANGE_EN
                  code_wr = (digit_cnt == 3'd4);
`endif
                  buffer_next = '0;
                  cnt_next    = '0;
                  next_state  = S_IDLE;
               end
            end
         end
         S_CHECK: begin
            buffer_next = '0;
            cnt_next    = '0;
            if ((digit_cnt == 3'd4) && (buffer == code)) begin
               err_next   = '0;
               next_state = S_OPEN;
            end else begin
               err_next   = err_inc;
               next_state = (err_inc == 2'(MAX_FAIL)) ? S_LOCKOUT : S_FAIL;
            end
         end
         S_OPEN: begin
            if (expired || is_clear) next_state = S_IDLE;
`ifdef LOCK_CODE_CHANGE_EN
            else if (is_enter)       next_state = S_NEWCODE;
`endif
         end
         S_FAIL: begin
            if (expired) next_state = S_IDLE;
         end
         S_LOCKOUT: begin
            if (expired) begin
               err_next   = '0;
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   // datapath and outputs registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_d    <= 1'b0;
         timer     <= '0;
         buffer    <= '0;
         digit_cnt <= '0;
         err_cnt   <= '0;
         unlock    <= 1'b0;
         fail      <= 1'b0;
         alarm     <= 1'b0;
      end else begin
         flag_d    <= key_flag;
         timer     <= ((next_state != state) || key_ok || (next_state == S_IDLE))
                      ? '0 : timer + 29'd1;
         buffer    <= buffer_next;
         digit_cnt <= cnt_next;
         err_cnt   <= err_next;
         unlock    <= (next_state == S_OPEN);
         fail      <= (next_state == S_FAIL);
         alarm     <= (next_state == S_LOCKOUT);
      end
   end

`ifdef LOCK_CODE_CHANGE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code     <= DEFAULT_CODE;
         code_upd <= 1'b0;
      end else begin
         code_upd <= code_wr;
         if (code_wr) code <= buffer;
      end
   end
`else
   assign code     = DEFAULT_CODE;
   assign code_upd = 1'b0;
`endif

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: directed scenarios plus random attempts checked
// against a digit-queue model of the lock.
module tb_lock_ctrl;
  localparam int OPEN_C = 20;
  localparam int FAIL_C = 10;
  localparam int LOCK_C = 40;
  localparam int IDLE_C = 30;
  localparam logic [15:0] DEF_CODE = 16'h1234;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_flag = 1'b0;
  logic [3:0] key_value = 4'd0;
  logic       unlock, fail, alarm, code_upd;
  logic [2:0] digit_cnt;
  logic [1:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int upd_seen = 0;

  logic [15:0] model_code = DEF_CODE;
  int          model_err = 0;
  int          q[$];

  lock_ctrl #(
    .DEFAULT_CODE(DEF_CODE),
    .OPEN_CYCLES(OPEN_C),
    .FAIL_CYCLES(FAIL_C),
    .LOCK_CYCLES(LOCK_C),
    .IDLE_CYCLES(IDLE_C),
    .MAX_FAIL(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_flag(key_flag),
    .key_value(key_value),
    .unlock(unlock),
    .fail(fail),
    .alarm(alarm),
    .digit_cnt(digit_cnt),
    .err_cnt(err_cnt),
    .code_upd(code_upd)
  );

  // clock/reset
  always #5 clk = ~clk;

  always @(negedge clk) if (code_upd === 1'b1) upd_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel_out(input int kind);
    case (kind)
      0:       return unlock;
      1:       return fail;
      default: return alarm;
    endcase
  endfunction

  // driver: strobe one cycle, hold value, return when the key has taken effect
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_flag  = 1'b1;
    key_value = k;
    @(negedge clk);
    key_flag = 1'b0;
    @(negedge clk);
  endtask

  task automatic digit(input int d);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    if (q.size() < 4) q.push_back(d);
    press(4'(d));
    check("digit_cnt", {29'd0, digit_cnt}, q.size());
  endtask

  task automatic star();
    q.delete();
    press(4'd10);
    check("star_clear", {29'd0, digit_cnt}, 0);
  endtask

  task automatic enter(input string tag, input int noise, input bit do_measure);
    logic [2:0] exp_out;
    int exp_len, kind, cnt;
    bit match;
    press(4'd11);
    if (q.size() == 0) begin
      check({tag, "_ignored"}, {29'd0, unlock, fail, alarm}, 0);
      return;
    end
    match = (q.size() == 4);
    foreach (q[i]) if (q[i] != int'(model_code[15-4*i -: 4])) match = 1'b0;
    q.delete();
    if (match) begin
      model_err = 0; kind = 0; exp_len = OPEN_C;
    end else begin
      model_err++;
      if (model_err == 3) begin kind = 2; exp_len = LOCK_C; end
      else begin kind = 1; exp_len = FAIL_C; end
    end
    exp_out = 3'b100 >> kind;
    check({tag, "_check_cycle"}, {29'd0, unlock, fail, alarm}, 0);
    @(negedge clk);
    check({tag, "_outputs"}, {29'd0, unlock, fail, alarm}, exp_out);
    check({tag, "_err_cnt"}, {30'd0, err_cnt}, model_err);
    check({tag, "_digits_cleared"}, {29'd0, digit_cnt}, 0);
    if (!do_measure) return;
    cnt = 1;
    for (int n = 0; n < noise; n++) begin
      press(4'($urandom_range(0, 9)));
      cnt += 3;
      check({tag, "_noise_held"}, {31'd0, sel_out(kind)}, 1);
      check({tag, "_noise_ignored"}, {29'd0, digit_cnt}, 0);
    end
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (sel_out(kind) !== 1'b1) break;
      cnt++;
    end
    check({tag, "_length"}, cnt, exp_len);
    if (kind == 2) begin
      model_err = 0;
      check({tag, "_err_cleared"}, {30'd0, err_cnt}, 0);
    end
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 0; i < 4; i++) digit(int'(c[15-4*i -: 4]));
  endtask

  initial begin
    int cnt;
    int r;
    // reset state
    repeat (2) @(negedge clk);
    check("rst_unlock", {31'd0, unlock}, 0);
    check("rst_fail", {31'd0, fail}, 0);
    check("rst_alarm", {31'd0, alarm}, 0);
    check("rst_digit_cnt", {29'd0, digit_cnt}, 0);
    check("rst_err_cnt", {30'd0, err_cnt}, 0);
    check("rst_code_upd", {31'd0, code_upd}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // correct code unlocks
    enter_code(16'h1234);
    enter("good", 0, 1);

    // three wrong attempts: two fails then lockout with ignored digits
    enter_code(16'h1235);
    enter("bad1", 0, 1);
    enter_code(16'h1235);
    enter("bad2", 0, 1);
    enter_code(16'h1235);
    enter("bad3", 3, 1);

    // short entry, then saturating entry
    digit(1); digit(2);
    enter("short", 0, 1);
    for (int i = 0; i < 5; i++) digit(9);
    enter("long", 0, 1);

    // entry timeout: no failure counted
    digit(1); digit(2);
    repeat (IDLE_C - 1) @(negedge clk);
    check("timeout_before", {29'd0, digit_cnt}, 2);
    @(negedge clk);
    check("timeout_after", {29'd0, digit_cnt}, 0);
    check("timeout_err", {30'd0, err_cnt}, model_err);
    q.delete();

    // '*' clears, '#' on empty entry ignored
    digit(4); star();
    enter("empty_hash", 0, 1);
    enter_code(16'h1234);
    enter("good2", 0, 1);

    // code change from OPEN
    enter_code(16'h1234);
    enter("cc_open", 0, 0);
    press(4'd11);
`ifdef LOCK_CODE_CHANGE_EN
    check("cc_newcode_unlock", {31'd0, unlock}, 0);
    enter_code(16'h5678);
    press(4'd11);
    check("cc_code_upd_high", {31'd0, code_upd}, 1);
    @(negedge clk);
    check("cc_code_upd_low", {31'd0, code_upd}, 0);
    model_code = 16'h5678;
    q.delete();
    check("cc_upd_count", upd_seen, 1);
`else
    check("cc_hash_ignored", {31'd0, unlock}, 1);
    for (int d = 5; d <= 8; d++) press(4'(d));
    press(4'd11);
    check("cc_open_held", {31'd0, unlock}, 1);
    check("cc_digits_ignored", {29'd0, digit_cnt}, 0);
    cnt = 19;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (unlock !== 1'b1) break;
      cnt++;
    end
    check("cc_open_length", cnt, OPEN_C);
    check("cc_upd_count", upd_seen, 0);
`endif
    enter_code(16'h1234);
    enter("cc_old", 0, 1);
    enter_code(16'h5678);
    enter("cc_new", 0, 1);

    // asynchronous reset during OPEN restores the default code
    enter_code(model_code);
    enter("pre_reset", 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_unlock", {31'd0, unlock}, 0);
    check("async_rst_err", {30'd0, err_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_code = DEF_CODE;
    model_err = 0;
    q.delete();
    enter_code(16'h1234);
    enter("post_reset", 0, 1);

    // random attempts
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        enter_code(model_code);
      end else begin
        for (int n = $urandom_range(1, 6); n > 0; n--) digit($urandom_range(0, 9));
        if (r == 3) begin
          press(4'($urandom_range(12, 15)));
          check("rand_ignored_key", {29'd0, digit_cnt}, q.size());
          if ($urandom_range(0, 1) == 1) star();
          for (int n = $urandom_range(0, 4); n > 0; n--) digit($urandom_range(0, 9));
        end
      end
      enter("rand", $urandom_range(0, 2), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
